// File: rtl/keypad_timer_entry.sv
// Keypad-to-BCD time entry. It synchronises and debounces the digit and clear keys, then
// shifts accepted digits into a BCD register and strobes loadn on every update.
//  state   | meaning
//  IDLE    | no key seen, waiting for a press
//  PRESS   | key pattern present, waiting for it to stay stable
//  HELD    | event taken for this press, waiting for release
//  RELEASE | keys gone, waiting for a stable release before rearming
module keypad_timer_entry #(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              holdn,
  input  logic [9:0]                        keys,
  input  logic                              clear_key,
  output logic [4*NUM_DIGITS-1:0]           digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic                              loadn,
  output logic                              time_valid,
  output logic                              key_error
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int NW = $clog2(NUM_DIGITS+1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES-1);
  localparam logic [NW-1:0] CNT_FULL = NW'(NUM_DIGITS);
  localparam logic [10:0]   CLEAR_V  = 11'h400;

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

  state_t        state, state_next;
  logic [10:0]   sync1, s, s_prev;
  logic [CW-1:0] cnt;
  logic          settled, accept, is_digit, is_clear;
  logic [3:0]    idx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1  <= '0;
      s      <= '0;
      s_prev <= '0;
      cnt    <= '0;
    end else begin
      sync1  <= {clear_key, keys};
      s      <= sync1;
      s_prev <= s;
      if (s != s_prev)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  // cnt lags a change by one cycle, so stability also requires s == s_prev right now
  assign settled = (s == s_prev) && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE:    if (s != '0) state_next = PRESS;
      PRESS: begin
        if (s == '0)
          state_next = IDLE;
        else if (settled) begin
          accept     = 1'b1;
          state_next = HELD;
        end
      end
      HELD:    if (s == '0) state_next = RELEASE;
      RELEASE: begin
        if (s != '0)
          state_next = HELD;
        else if (settled)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    idx      = '0;
    is_clear = (s == CLEAR_V);
    is_digit = !s[10] && $onehot(s[9:0]);
    for (int i = 0; i < 10; i++)
      if (s[i]) idx = 4'(i);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      digits      <= '0;
      digit_count <= '0;
      loadn       <= 1'b1;
      key_error   <= 1'b0;
    end else begin
      loadn     <= 1'b1;
      key_error <= 1'b0;
      if (accept && holdn) begin
        if (is_digit) begin
          digits <= {digits[4*NUM_DIGITS-5:0], idx};
          if (digit_count != CNT_FULL)
            digit_count <= digit_count + 1'b1;
          loadn <= 1'b0;
        end else if (is_clear) begin
          digits      <= '0;
          digit_count <= '0;
          loadn       <= 1'b0;
        end else begin
          key_error <= 1'b1;
        end
      end
    end
  end

  assign time_valid = (digits[7:4] <= 4'd5) && (digits != '0);

endmodule

// File: tb/tb_keypad_timer_entry.sv
// Directed bench for keypad_timer_entry: a 4-digit and a 6-digit instance share the
// same keypad stimulus; expected register contents are hand-computed.
module tb_keypad_timer_entry;

  logic        clk = 1'b0;
  logic        resetn, holdn, clear_key;
  logic [9:0]  keys;

  logic [15:0] digits4;
  logic [2:0]  count4;
  logic        loadn4, tv4, kerr4;
  logic [23:0] digits6;
  logic [2:0]  count6;
  logic        loadn6, tv6, kerr6;

  int checks = 0;
  int errors = 0;
  int lo4 = 0, lo6 = 0, ke4 = 0;
  int lo_base, ke_base;

  always #5 clk = ~clk;

  keypad_timer_entry #(.NUM_DIGITS(4), .DEBOUNCE_CYCLES(4)) dut4 (
    .clk(clk), .resetn(resetn), .holdn(holdn), .keys(keys), .clear_key(clear_key),
    .digits(digits4), .digit_count(count4), .loadn(loadn4), .time_valid(tv4),
    .key_error(kerr4));

  keypad_timer_entry #(.NUM_DIGITS(6), .DEBOUNCE_CYCLES(4)) dut6 (
    .clk(clk), .resetn(resetn), .holdn(holdn), .keys(keys), .clear_key(clear_key),
    .digits(digits6), .digit_count(count6), .loadn(loadn6), .time_valid(tv6),
    .key_error(kerr6));

  always @(negedge clk) begin
    if (!loadn4) lo4++;
    if (!loadn6) lo6++;
    if (kerr4)   ke4++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [10:0] v);
    {clear_key, keys} = v;
    step(8);
    {clear_key, keys} = '0;
    step(10);
  endtask

  function automatic logic [10:0] dk(input int d);
    logic [10:0] v;
    v = '0;
    v[d] = 1'b1;
    return v;
  endfunction

  initial begin
    resetn = 1'b0; holdn = 1'b1; keys = '0; clear_key = 1'b0;
    step(3);
    chk("rst_digits", 32'(digits4), 32'h0);
    chk("rst_count", 32'(count4), 32'd0);
    chk("rst_loadn", 32'(loadn4), 32'd1);
    chk("rst_kerr", 32'(kerr4), 32'd0);
    chk("rst_tv", 32'(tv4), 32'd0);
    resetn = 1'b1;
    step(2);

    // case 1: loadn low only in cycle 7 after the key reaches the pin
    keys[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("c1_loadn_cyc%0d", k), 32'(loadn4), (k == 7) ? 32'd0 : 32'd1);
      if (k == 6) chk("c1_digits_pre", 32'(digits4), 32'h0);
      if (k == 7) chk("c1_digits_upd", 32'(digits4), 32'h0003);
    end
    @(posedge clk); #1;
    keys = '0;
    step(10);
    chk("c1_count", 32'(count4), 32'd1);
    chk("c1_tv", 32'(tv4), 32'd1);

    // case 2, both widths
    press(11'h400);
    chk("c2_clear", 32'(digits4), 32'h0);
    press(dk(1)); press(dk(2)); press(dk(3)); press(dk(0));
    chk("c2_1230", 32'(digits4), 32'h1230);
    chk("c2_cnt4", 32'(count4), 32'd4);
    chk("c2_n6_1230", 32'(digits6), 32'h001230);
    press(dk(5));
    chk("c2_2305", 32'(digits4), 32'h2305);
    chk("c2_cnt_sat", 32'(count4), 32'd4);
    chk("c2_n6_5th", 32'(digits6), 32'h012305);
    chk("c2_n6_cnt5", 32'(count6), 32'd5);
    press(dk(7));
    chk("c2_3057", 32'(digits4), 32'h3057);
    chk("c2_tv_d1_5", 32'(tv4), 32'd1);
    chk("c2_n6_6th", 32'(digits6), 32'h123057);
    press(dk(8));
    chk("c2_0578", 32'(digits4), 32'h0578);
    chk("c2_tv_d1_7", 32'(tv4), 32'd0);
    chk("c2_n6_ovf", 32'(digits6), 32'h230578);
    chk("c2_n6_cnt6", 32'(count6), 32'd6);

    // case 3: bouncing key never settles
    lo_base = lo4; ke_base = ke4;
    for (int k = 0; k < 5; k++) begin
      keys[6] = 1'b1; step(2);
      keys[6] = 1'b0; step(2);
    end
    step(10);
    chk("c3_digits", 32'(digits4), 32'h0578);
    chk("c3_loadn", 32'(lo4 - lo_base), 32'd0);
    chk("c3_kerr", 32'(ke4 - ke_base), 32'd0);

    // case 4: two digits at once
    lo_base = lo4; ke_base = ke4;
    keys = 10'b0000100100;
    step(10);
    keys = '0;
    step(10);
    chk("c4_kerr_pulse", 32'(ke4 - ke_base), 32'd1);
    chk("c4_loadn", 32'(lo4 - lo_base), 32'd0);
    chk("c4_digits", 32'(digits4), 32'h0578);

    // case 5: holdn freezes entry
    lo_base = lo4;
    holdn = 1'b0;
    press(dk(9));
    chk("c5_frozen", 32'(digits4), 32'h0578);
    keys[9] = 1'b1;
    step(8);
    holdn = 1'b1;
    step(6);
    keys = '0;
    step(10);
    chk("c5_held_rise", 32'(digits4), 32'h0578);
    chk("c5_no_loadn", 32'(lo4 - lo_base), 32'd0);
    press(dk(9));
    chk("c5_d0_9", 32'(digits4), 32'h5789);
    chk("c5_loadn", 32'(lo4 - lo_base), 32'd1);
    chk("c5_n6", 32'(digits6), 32'h305789);

    // case 6: clear, clear on zero, reset mid-press and mid-strobe
    lo_base = lo4;
    press(11'h400);
    chk("c6_clear", 32'(digits4), 32'h0);
    chk("c6_cnt0", 32'(count4), 32'd0);
    chk("c6_tv0", 32'(tv4), 32'd0);
    press(11'h400);
    chk("c6_loadn2", 32'(lo4 - lo_base), 32'd2);
    press(dk(4));
    chk("c6_0004", 32'(digits4), 32'h0004);
    keys[5] = 1'b1;
    step(4);
    resetn = 1'b0;
    #1;
    chk("c6_rst_digits", 32'(digits4), 32'h0);
    chk("c6_rst_count", 32'(count4), 32'd0);
    chk("c6_rst_n6", 32'(digits6), 32'h0);
    resetn = 1'b1;
    step(10);
    chk("c6_reaccept", 32'(digits4), 32'h0005);
    chk("c6_reaccept_cnt", 32'(count4), 32'd1);
    keys = '0;
    step(10);
    keys[7] = 1'b1;
    step(7);
    chk("c6_strobe_low", 32'(loadn4), 32'd0);
    chk("c6_strobe_dig", 32'(digits4), 32'h0057);
    resetn = 1'b0;
    #1;
    chk("c6_strobe_rst", 32'(loadn4), 32'd1);
    chk("c6_strobe_dig0", 32'(digits4), 32'h0);
    keys = '0;
    resetn = 1'b1;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
